// File: rtl/vec_cpu_pkg.sv
// Shared definitions for the sequential vector CPU: opcodes, FSM states and
// width helpers used to size ports and internal fields.
package vec_cpu_pkg;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_INIT  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_MEMRD = 2'd2,
    S_ALU   = 2'd3
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int vec_w(input int lanes, input int elem_w);
    return lanes * elem_w;
  endfunction

endpackage

// File: rtl/vec_mem.sv
// Private vector memory: synchronous write, one-cycle registered read, no reset.
module vec_mem #(
  parameter int DEPTH  = 512,
  parameter int WIDTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Callers only assert i_we/i_re for addresses below DEPTH.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) o_rdata       <= r_mem[i_addr];
  end

endmodule

// File: rtl/vec_cpu_seq.sv
// Handshaked vector CPU: one instruction at a time, ADD/MUL processed one lane
// per cycle with a double-width result split across the rd / rd+1 pair.
module vec_cpu_seq
  import vec_cpu_pkg::*;
#(
  parameter int LANES     = 16,
  parameter int ELEM_W    = 32,
  parameter int NUM_REGS  = 4,
  parameter int MEM_DEPTH = 512,
  parameter int ADDR_W    = 9
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               instr_valid,
  output logic                               instr_ready,
  input  logic [2:0]                         opcode,
  input  logic [$clog2(NUM_REGS)-1:0]        rd,
  input  logic [$clog2(NUM_REGS)-1:0]        rs1,
  input  logic [$clog2(NUM_REGS)-1:0]        rs2,
  input  logic [ADDR_W-1:0]                  mem_addr,
  input  logic [LANES*ELEM_W-1:0]            init_value,
  output logic                               done,
  output logic                               err,
  output logic                               busy,
  output logic [NUM_REGS*LANES*ELEM_W-1:0]   reg_out
);

  localparam int VW = vec_w(LANES, ELEM_W);
  localparam int RW = $clog2(NUM_REGS);
  localparam int LW = idx_w(LANES);
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [LW-1:0]   LAST_LN  = LW'(LANES-1);

  typedef struct packed {
    logic [2:0]        op;
    logic [RW-1:0]     rd;
    logic [RW-1:0]     rs1;
    logic [RW-1:0]     rs2;
    logic [ADDR_W-1:0] addr;
    logic [VW-1:0]     init;
  } req_t;

  state_e r_state, w_next;
  req_t   r_req;
  logic [NUM_REGS-1:0][LANES-1:0][ELEM_W-1:0] r_regs;
  logic [LW-1:0] r_lane;
  logic r_done, r_err;

  logic w_done_n, w_err_n, w_mem_we, w_mem_re, w_alu_step, w_last, w_addr_ok;
  logic [VW-1:0]          w_rdata;
  logic [RW-1:0]          w_rd_hi;
  logic [ELEM_W-1:0]      w_a, w_b;
  logic signed [2*ELEM_W-1:0] w_ax, w_bx, w_res;

  assign instr_ready = (r_state == S_IDLE);
  assign busy        = !instr_ready;
  assign done        = r_done;
  assign err         = r_err;
  assign reg_out     = r_regs;

  assign w_addr_ok = ({1'b0, r_req.addr} < DEPTH_L);
  assign w_last    = (r_lane == LAST_LN);
  assign w_rd_hi   = r_req.rd + 1'b1;

  // Lane ALU: operands sampled before the lane is written, so aliasing is safe.
  assign w_a   = r_regs[r_req.rs1][r_lane];
  assign w_b   = r_regs[r_req.rs2][r_lane];
  assign w_ax  = {{ELEM_W{w_a[ELEM_W-1]}}, w_a};
  assign w_bx  = {{ELEM_W{w_b[ELEM_W-1]}}, w_b};
  assign w_res = (r_req.op == OP_ADD) ? (w_ax + w_bx) : (w_ax * w_bx);

  vec_mem #(.DEPTH(MEM_DEPTH), .WIDTH(VW), .ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (r_req.addr),
    .i_wdata (r_regs[r_req.rs1]),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_next     = r_state;
    w_done_n   = 1'b0;
    w_err_n    = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_re   = 1'b0;
    w_alu_step = 1'b0;
    case (r_state)
      S_IDLE: if (instr_valid) w_next = S_EXEC;
      S_EXEC: begin
        case (r_req.op)
          OP_LOAD: begin
            w_mem_re = w_addr_ok;
            w_next   = S_MEMRD;
          end
          OP_STORE: begin
            w_mem_we = w_addr_ok;
            w_err_n  = !w_addr_ok;
            w_done_n = 1'b1;
            w_next   = S_IDLE;
          end
          // Lane 0 is produced in EXEC so the last lane lands at E(LANES).
          OP_ADD, OP_MUL: begin
            w_alu_step = 1'b1;
            w_done_n   = w_last;
            w_next     = w_last ? S_IDLE : S_ALU;
          end
          OP_INIT: begin
            w_done_n = 1'b1;
            w_next   = S_IDLE;
          end
          default: begin
            w_err_n  = 1'b1;
            w_done_n = 1'b1;
            w_next   = S_IDLE;
          end
        endcase
      end
      S_MEMRD: begin
        w_err_n  = !w_addr_ok;
        w_done_n = 1'b1;
        w_next   = S_IDLE;
      end
      S_ALU: begin
        w_alu_step = 1'b1;
        w_done_n   = w_last;
        if (w_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_req   <= '0;
      r_regs  <= '0;
      r_lane  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
      if (r_state == S_IDLE && instr_valid)
        r_req <= '{op: opcode, rd: rd, rs1: rs1, rs2: rs2, addr: mem_addr, init: init_value};
      if (r_state == S_EXEC && r_req.op == OP_INIT)
        r_regs[r_req.rd] <= r_req.init;
      if (r_state == S_MEMRD)
        r_regs[r_req.rd] <= w_addr_ok ? w_rdata : '0;
      if (w_alu_step) begin
        r_regs[r_req.rd][r_lane] <= w_res[ELEM_W-1:0];
        r_regs[w_rd_hi][r_lane]  <= w_res[2*ELEM_W-1:ELEM_W];
        r_lane <= w_last ? '0 : r_lane + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vec_cpu_seq.sv
// Randomised bench for vec_cpu_seq against an instruction-level reference model.
module tb_vec_cpu_seq;
  import vec_cpu_pkg::*;

  localparam int LANES = 16, ELEM_W = 32, NUM_REGS = 4, MEM_DEPTH = 300, ADDR_W = 9;
  localparam int VW = LANES * ELEM_W;
  localparam int RW = $clog2(NUM_REGS);

  logic clk = 1'b0, rst_n = 1'b0;
  logic vld = 1'b0, rdy, done, err, busy;
  logic [2:0] op = '0;
  logic [RW-1:0] s_rd = '0, s_rs1 = '0, s_rs2 = '0;
  logic [ADDR_W-1:0] s_addr = '0;
  logic [VW-1:0] s_init = '0;
  logic [NUM_REGS*VW-1:0] reg_out;

  vec_cpu_seq #(.LANES(LANES), .ELEM_W(ELEM_W), .NUM_REGS(NUM_REGS),
                .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(vld), .instr_ready(rdy),
    .opcode(op), .rd(s_rd), .rs1(s_rs1), .rs2(s_rs2), .mem_addr(s_addr),
    .init_value(s_init), .done(done), .err(err), .busy(busy), .reg_out(reg_out)
  );

  always #5 clk = ~clk;

  logic [ELEM_W-1:0] m_reg [NUM_REGS][LANES];
  logic [VW-1:0]     m_mem [int];
  int st_q [$];
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] m_vec(input int k);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*ELEM_W +: ELEM_W] = m_reg[k][i];
    return v;
  endfunction

  function automatic logic [VW-1:0] splat(input logic [ELEM_W-1:0] e);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*ELEM_W +: ELEM_W] = e;
    return v;
  endfunction

  task automatic check_regs(input string tag);
    for (int k = 0; k < NUM_REGS; k++)
      chk($sformatf("%s_r%0d", tag, k), reg_out[k*VW +: VW], m_vec(k));
  endtask

  task automatic m_clear();
    for (int k = 0; k < NUM_REGS; k++)
      for (int i = 0; i < LANES; i++) m_reg[k][i] = '0;
  endtask

  // Architectural effect of one instruction, plus its expected err and latency.
  task automatic model_exec(input logic [2:0] o, input int d, input int a1, input int a2,
                            input int ad, input logic [VW-1:0] iv,
                            output logic e, output int lat);
    longint a, b, r;
    e = 1'b0; lat = 1;
    case (o)
      OP_LOAD: begin
        lat = 2;
        if (ad < MEM_DEPTH) begin
          for (int i = 0; i < LANES; i++) m_reg[d][i] = m_mem[ad][i*ELEM_W +: ELEM_W];
        end else begin
          e = 1'b1;
          for (int i = 0; i < LANES; i++) m_reg[d][i] = '0;
        end
      end
      OP_STORE: if (ad < MEM_DEPTH) m_mem[ad] = m_vec(a1); else e = 1'b1;
      OP_ADD, OP_MUL: begin
        lat = LANES;
        for (int i = 0; i < LANES; i++) begin
          a = $signed(m_reg[a1][i]);
          b = $signed(m_reg[a2][i]);
          r = (o == OP_ADD) ? a + b : a * b;
          m_reg[d][i] = r[31:0];
          m_reg[(d + 1) % NUM_REGS][i] = r[63:32];
        end
      end
      OP_INIT: for (int i = 0; i < LANES; i++) m_reg[d][i] = iv[i*ELEM_W +: ELEM_W];
      default: e = 1'b1;
    endcase
  endtask

  // Issue from the IDLE phase (#1 after a rising edge); optionally wave a
  // conflicting INIT at the port while busy to show it is ignored.
  task automatic run(input string tag, input logic [2:0] o, input int d, input int a1,
                     input int a2, input int ad, input logic [VW-1:0] iv, input bit hold);
    logic e; int lat, cyc, bcnt;
    chk({tag, "_rdy"}, rdy, 1'b1);
    op = o; s_rd = RW'(d); s_rs1 = RW'(a1); s_rs2 = RW'(a2); s_addr = ADDR_W'(ad); s_init = iv;
    vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    model_exec(o, d, a1, a2, ad, iv, e, lat);
    cyc = 0; bcnt = 0;
    while (cyc < 64 && !done) begin
      if (busy && !rdy) bcnt++;
      if (hold && cyc >= 1 && cyc < lat - 1) begin
        vld = 1'b1; op = OP_INIT; s_rd = '0; s_init = '1;
      end else vld = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    vld = 1'b0;
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_busy"}, bcnt, lat);
    chk({tag, "_err"}, err, e);
    check_regs(tag);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {done, err}, 2'b00);
  endtask

  initial begin
    logic [2:0] o; int ad; logic [VW-1:0] iv;
    m_clear();
    #23 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", rdy, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", {done, err}, 2'b00);
    check_regs("rst");

    run("init5",  OP_INIT, 0, 0, 0, 0, splat(32'd5), 0);
    run("initm3", OP_INIT, 1, 0, 0, 0, splat(32'hFFFFFFFD), 0);
    run("mul",    OP_MUL,  2, 0, 1, 0, '0, 1);
    chk("mul_lo", reg_out[2*VW +: VW], splat(32'hFFFFFFF1));
    chk("mul_hi", reg_out[3*VW +: VW], splat(32'hFFFFFFFF));
    run("initmx", OP_INIT, 0, 0, 0, 0, splat(32'h7FFFFFFF), 0);
    run("addal",  OP_ADD,  0, 0, 0, 0, '0, 0);
    chk("add_lo", reg_out[0 +: VW], splat(32'hFFFFFFFE));
    chk("add_hi", reg_out[VW +: VW], '0);
    run("st299",  OP_STORE, 0, 2, 0, 299, '0, 0);
    st_q.push_back(299);
    run("clr2",   OP_INIT, 2, 0, 0, 0, '0, 0);
    run("ld299",  OP_LOAD, 2, 0, 0, 299, '0, 0);
    chk("ld_rest", reg_out[2*VW +: VW], splat(32'hFFFFFFF1));
    run("st300",  OP_STORE, 0, 1, 0, 300, '0, 0);
    run("ill7",   3'd7, 1, 2, 3, 0, '0, 0);
    run("ld511",  OP_LOAD, 0, 0, 0, 511, '0, 0);

    for (int n = 0; n < 40; n++) begin
      o = 3'($urandom % 8);
      for (int i = 0; i < LANES; i++) iv[i*ELEM_W +: ELEM_W] = $urandom;
      ad = int'($urandom % 512);
      if (o == OP_LOAD) begin
        if (st_q.size() > 0 && ($urandom % 4) != 0) ad = st_q[$urandom % st_q.size()];
        else ad = MEM_DEPTH + int'($urandom % (512 - MEM_DEPTH));
      end
      if (o == OP_STORE && ad < MEM_DEPTH) st_q.push_back(ad);
      run($sformatf("rnd%0d", n), o, int'($urandom % NUM_REGS), int'($urandom % NUM_REGS),
          int'($urandom % NUM_REGS), ad, iv, ($urandom % 2) == 1);
    end

    // Reset in the middle of a MUL: registers clear at once, no done.
    op = OP_MUL; s_rd = 2'd2; s_rs1 = 2'd0; s_rs2 = 2'd1; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    m_clear();
    check_regs("arst");
    chk("arst_done", {done, err}, 2'b00);
    chk("arst_rdy", {rdy, busy}, 2'b10);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done) chk("arst_nodone", done, 1'b0);
    end
    run("postrst", OP_INIT, 3, 0, 0, 0, splat(32'hA5A5_0001), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
